// File: rtl/clk_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// clk_ctrl_pkg : state codes and strobe lane helpers for the set-mode sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package clk_ctrl_pkg;

   typedef enum logic [2:0] {
      RUN       = 3'd0,
      SET_HRS   = 3'd1,
      SET_MIN   = 3'd2,
      SET_MONTH = 3'd3,
      SET_DATE  = 3'd4,
      SET_DAY   = 3'd5,
      AL_HRS    = 3'd6,
      AL_MIN    = 3'd7
   } set_state_t;

   localparam int unsigned STB_W     = 5;
   localparam int unsigned STB_HRS   = 0;
   localparam int unsigned STB_MIN   = 1;
   localparam int unsigned STB_MONTH = 2;
   localparam int unsigned STB_DATE  = 3;
   localparam int unsigned STB_DAY   = 4;

   function automatic int unsigned cnt_width(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m + 1);
   endfunction

   // Alarm fields share the hour/minute advance lines with the time fields.
   function automatic logic [STB_W-1:0] field_strobe(input set_state_t s);
      logic [STB_W-1:0] r;
      r = '0;
      case (s)
         SET_HRS, AL_HRS: r[STB_HRS]   = 1'b1;
         SET_MIN, AL_MIN: r[STB_MIN]   = 1'b1;
         SET_MONTH:       r[STB_MONTH] = 1'b1;
         SET_DATE:        r[STB_DATE]  = 1'b1;
         SET_DAY:         r[STB_DAY]   = 1'b1;
         default:         r = '0;
      endcase
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/btn_edge.sv
// ---------------------------------------------------------------------------
// btn_edge : button synchroniser, rise detector and optional hold-to-repeat
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module btn_edge #(
   parameter bit          REPEAT   = 1'b0,
   parameter int unsigned HOLD_DLY = 4,
   parameter int unsigned RPT_PER  = 2,
   parameter int unsigned CNT_W    = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic btn,
   output logic rise,
   output logic evt
);

   logic s1_q, s1_d;
   logic s2_q, s2_d;

   always_comb begin
      s1_d = btn;
      s2_d = s1_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
      end
   end

   assign rise = s1_q & ~s2_q;

   generate
      if (REPEAT) begin : g_repeat
         localparam logic [CNT_W-1:0] C_HOLD = CNT_W'(HOLD_DLY);
         localparam logic [CNT_W-1:0] C_LAST = CNT_W'(HOLD_DLY + RPT_PER - 1);

         logic [CNT_W-1:0] hold_q, hold_d;
         logic             rpt;

         // Once the hold delay is reached the count loops over the last
         // RPT_PER values so repeats keep coming for as long as the button is held.
         always_comb begin
            hold_d = hold_q;
            if (!s1_q || clr) begin
               hold_d = '0;
            end else if (hold_q == C_LAST) begin
               hold_d = C_HOLD;
            end else if (hold_q != '1) begin
               hold_d = hold_q + CNT_W'(1);
            end
         end

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               hold_q <= '0;
            end else begin
               hold_q <= hold_d;
            end
         end

         assign rpt = s1_q && (hold_q == C_HOLD);
         assign evt = rise | rpt;
      end else begin : g_no_repeat
         logic unused_clr;
         assign unused_clr = clr;
         assign evt        = rise;
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/set_mode_ctrl.sv
// ---------------------------------------------------------------------------
// set_mode_ctrl : mode/adv/alarm button sequencer driving clock field advances
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module set_mode_ctrl
   import clk_ctrl_pkg::*;
#(
   parameter int unsigned HOLD_DLY = 4,
   parameter int unsigned RPT_PER  = 2,
   parameter int unsigned TIMEOUT  = 30
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       mode_btn,
   input  logic       adv_btn,
   input  logic       alarm_btn,
   output logic       timeset,
   output logic       alarmset,
   output logic       hrsadv,
   output logic       minadv,
   output logic       monthadv,
   output logic       dateadv,
   output logic       dayadv,
   output logic [2:0] field
);

   localparam int unsigned       CNT_W       = cnt_width(HOLD_DLY, RPT_PER, TIMEOUT);
   localparam logic [CNT_W-1:0]  C_IDLE_LAST = CNT_W'(TIMEOUT - 1);

   set_state_t       state_q, state_d;
   logic [CNT_W-1:0] idle_q, idle_d;
   logic [STB_W-1:0] stb_q, stb_d;

   logic mode_rise, mode_evt;
   logic adv_rise, adv_evt;
   logic alarm_rise, alarm_evt;
   logic any_rise, timeout, state_chg;

   btn_edge #(.REPEAT(1'b0), .HOLD_DLY(HOLD_DLY), .RPT_PER(RPT_PER), .CNT_W(CNT_W)) u_mode (
      .clk  (clk),
      .rst  (rst),
      .clr  (state_chg),
      .btn  (mode_btn),
      .rise (mode_rise),
      .evt  (mode_evt)
   );

   btn_edge #(.REPEAT(1'b1), .HOLD_DLY(HOLD_DLY), .RPT_PER(RPT_PER), .CNT_W(CNT_W)) u_adv (
      .clk  (clk),
      .rst  (rst),
      .clr  (state_chg),
      .btn  (adv_btn),
      .rise (adv_rise),
      .evt  (adv_evt)
   );

   btn_edge #(.REPEAT(1'b0), .HOLD_DLY(HOLD_DLY), .RPT_PER(RPT_PER), .CNT_W(CNT_W)) u_alarm (
      .clk  (clk),
      .rst  (rst),
      .clr  (state_chg),
      .btn  (alarm_btn),
      .rise (alarm_rise),
      .evt  (alarm_evt)
   );

   assign any_rise = mode_rise | adv_rise | alarm_rise;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= RUN;
         idle_q  <= '0;
         stb_q   <= '0;
      end else begin
         state_q <= state_d;
         idle_q  <= idle_d;
         stb_q   <= stb_d;
      end
   end

   // A pending button rise counts as activity, so it beats the idle timeout.
   always_comb begin
      state_d = state_q;
      timeout = (state_q != RUN) && (idle_q == C_IDLE_LAST) && !any_rise;
      if (mode_evt) begin
         case (state_q)
            RUN:       state_d = SET_HRS;
            SET_HRS:   state_d = SET_MIN;
            SET_MIN:   state_d = SET_MONTH;
            SET_MONTH: state_d = SET_DATE;
            SET_DATE:  state_d = SET_DAY;
            SET_DAY:   state_d = RUN;
            AL_HRS:    state_d = AL_MIN;
            AL_MIN:    state_d = RUN;
            default:   state_d = RUN;
         endcase
      end else if (alarm_evt && (state_q == RUN)) begin
         state_d = AL_HRS;
      end else if (timeout) begin
         state_d = RUN;
      end
      state_chg = (state_d != state_q);

      idle_d = idle_q;
      if (any_rise || state_chg || (state_q == RUN)) begin
         idle_d = '0;
      end else if (idle_q != '1) begin
         idle_d = idle_q + CNT_W'(1);
      end
   end

   always_comb begin
      stb_d = '0;
      if (adv_evt && !state_chg) begin
         stb_d = field_strobe(state_q);
      end
   end

   assign field    = state_q;
   assign timeset  = state_q inside {SET_HRS, SET_MIN, SET_MONTH, SET_DATE, SET_DAY};
   assign alarmset = state_q inside {AL_HRS, AL_MIN};
   assign hrsadv   = stb_q[STB_HRS];
   assign minadv   = stb_q[STB_MIN];
   assign monthadv = stb_q[STB_MONTH];
   assign dateadv  = stb_q[STB_DATE];
   assign dayadv   = stb_q[STB_DAY];

endmodule

`default_nettype wire

// File: tb/tb_set_mode_ctrl.sv
// ---------------------------------------------------------------------------
// tb_set_mode_ctrl : directed and randomized checks of set_mode_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_set_mode_ctrl;

   localparam int HOLD_DLY = 4;
   localparam int RPT_PER  = 2;
   localparam int TIMEOUT  = 30;

   localparam bit [2:0] B_MODE  = 3'b001;
   localparam bit [2:0] B_ADV   = 3'b010;
   localparam bit [2:0] B_ALARM = 3'b100;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       mode_btn = 1'b0;
   logic       adv_btn = 1'b0;
   logic       alarm_btn = 1'b0;
   logic       timeset, alarmset, hrsadv, minadv, monthadv, dateadv, dayadv;
   logic [2:0] field;

   int checks = 0;
   int errors = 0;
   bit run_cmp = 1'b0;

   always #5 clk = ~clk;

   set_mode_ctrl #(.HOLD_DLY(HOLD_DLY), .RPT_PER(RPT_PER), .TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .rst       (rst),
      .mode_btn  (mode_btn),
      .adv_btn   (adv_btn),
      .alarm_btn (alarm_btn),
      .timeset   (timeset),
      .alarmset  (alarmset),
      .hrsadv    (hrsadv),
      .minadv    (minadv),
      .monthadv  (monthadv),
      .dateadv   (dateadv),
      .dayadv    (dayadv),
      .field     (field)
   );

   // Reference model: everything is timed by edge index. cur/prev are the
   // button levels sampled at the last two edges; hold and idle lengths are
   // differences between the current edge and the edge that started them.
   typedef struct packed {
      int       state;
      bit [4:0] stb;
      int       adv_start;
      int       chg_edge;
      int       idle_ref;
      int       ecount;
      bit [2:0] cur;
      bit [2:0] prev;
   } mdl_t;

   mdl_t m;

   function automatic mdl_t mdl_reset();
      mdl_t r;
      r = '0;
      return r;
   endfunction

   function automatic mdl_t mdl_step(input mdl_t s, input bit [2:0] btn);
      mdl_t r;
      int   k, n, idle, nxt, lane;
      bit   rm, ra, rl, any, adv_evt;
      r    = s;
      k    = s.ecount;
      rm   = s.cur[0] & ~s.prev[0];
      ra   = s.cur[1] & ~s.prev[1];
      rl   = s.cur[2] & ~s.prev[2];
      any  = rm | ra | rl;
      n    = k - ((s.adv_start > s.chg_edge) ? s.adv_start : s.chg_edge);
      adv_evt = s.cur[1] && (ra || (n >= HOLD_DLY && ((n - HOLD_DLY) % RPT_PER) == 0));
      idle = k - s.idle_ref;
      if (rm)                                                   nxt = (s.state == 5 || s.state == 7) ? 0 : s.state + 1;
      else if (rl && s.state == 0)                              nxt = 6;
      else if (s.state != 0 && idle >= TIMEOUT - 1 && !any)     nxt = 0;
      else                                                      nxt = s.state;
      r.stb = 5'b0;
      if (adv_evt && nxt == s.state && s.state != 0) begin
         lane  = (s.state >= 6) ? s.state - 6 : s.state - 1;
         r.stb = 5'b00001 << lane;
      end
      if (nxt != s.state) r.chg_edge = k + 1;
      if (any || nxt != s.state || s.state == 0) r.idle_ref = k + 1;
      if (btn[1] && !s.cur[1]) r.adv_start = k + 1;
      r.state  = nxt;
      r.prev   = s.cur;
      r.cur    = btn;
      r.ecount = k + 1;
      return r;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) m <= mdl_reset();
      else      m <= mdl_step(m, {alarm_btn, adv_btn, mode_btn});
   end

   always @(negedge clk) begin
      if (run_cmp) begin
         checks++;
         if ({timeset, alarmset, dayadv, dateadv, monthadv, minadv, hrsadv, field} !==
             {(m.state >= 1 && m.state <= 5), (m.state >= 6), m.stb, m.state[2:0]}) begin
            errors++;
            $display("FAIL cycle_cmp t=%0t actual ts/as/stb/field=%b%b_%b_%0d required=%b%b_%b_%0d",
                     $time, timeset, alarmset, {dayadv, dateadv, monthadv, minadv, hrsadv}, field,
                     (m.state >= 1 && m.state <= 5), (m.state >= 6), m.stb, m.state);
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   logic [4:0] slog [0:31];
   logic [2:0] flog [0:31];

   // Drive btns at a falling edge, hold them for 'hold' cycles, and log
   // strobes/field at each of the next 'win' falling edges (index 1..win).
   task automatic watch(input bit [2:0] btns, input int hold, input int win);
      @(negedge clk);
      {alarm_btn, adv_btn, mode_btn} = btns;
      for (int i = 1; i <= win; i++) begin
         @(negedge clk);
         slog[i] = {dayadv, dateadv, monthadv, minadv, hrsadv};
         flog[i] = field;
         if (i == hold) {alarm_btn, adv_btn, mode_btn} = 3'b000;
      end
   endtask

   function automatic int smask(input int lane, input int win);
      int r;
      r = 0;
      for (int i = 1; i <= win; i++) if (slog[i][lane]) r |= (1 << i);
      return r;
   endfunction

   function automatic int anymask(input int win);
      int r;
      r = 0;
      for (int l = 0; l < 5; l++) r |= smask(l, win);
      return r;
   endfunction

   int exp_f [0:5];
   int t;
   int stb_seen;
   int quiet;

   initial begin
      exp_f[0] = 1; exp_f[1] = 2; exp_f[2] = 3; exp_f[3] = 4; exp_f[4] = 5; exp_f[5] = 0;

      #3 rst = 1'b0;
      #1;
      chk("reset_field", int'(field), 0);
      chk("reset_outs", int'({timeset, alarmset, dayadv, dateadv, monthadv, minadv, hrsadv}), 0);
      run_cmp = 1'b1;
      @(negedge clk) rst = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         watch(B_MODE, 1, 4);
         chk("mode_walk_field", int'(flog[4]), exp_f[i]);
         chk("mode_walk_timeset", int'(timeset), (exp_f[i] != 0) ? 1 : 0);
      end

      watch(B_ALARM, 1, 4);
      chk("alarm_field", int'(field), 6);
      chk("alarm_set", int'(alarmset), 1);
      watch(B_ADV, 1, 4);
      chk("alarm_hrsadv", smask(0, 4), 32'h4);
      chk("alarm_other_stb", anymask(4) & ~smask(0, 4), 0);
      watch(B_MODE, 1, 4);
      chk("alarm_min_field", int'(field), 7);
      watch(B_MODE, 1, 4);
      chk("alarm_exit_field", int'(field), 0);
      chk("alarm_exit_alarmset", int'(alarmset), 0);
      watch(B_ALARM | B_MODE, 1, 4);
      chk("mode_beats_alarm", int'(field), 1);

      watch(B_MODE | B_ADV, 1, 4);
      chk("mode_adv_field", int'(flog[4]), 2);
      chk("mode_adv_nostb", anymask(4), 0);

      watch(B_ADV, 10, 12);
      chk("repeat_minadv", smask(1, 12), 32'h544);
      chk("repeat_other_stb", anymask(12) & ~smask(1, 12), 0);

      watch(B_MODE, 1, 4);
      watch(B_MODE, 1, 2);
      chk("enter_set_date", int'(flog[2]), 4);
      t = 0;
      stb_seen = 0;
      while (field == 3'd4 && t < 60) begin
         @(negedge clk);
         t++;
         if ({dayadv, dateadv, monthadv, minadv, hrsadv} != 5'b0) stb_seen = 1;
      end
      chk("timeout_cycles", t, 30);
      chk("timeout_field", int'(field), 0);
      chk("timeout_nostb", stb_seen, 0);

      watch(B_MODE, 1, 4);
      watch(B_MODE, 1, 4);
      chk("rst_pre_field", int'(field), 2);
      @(negedge clk) adv_btn = 1'b1;
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("rst_async_field", int'(field), 0);
      chk("rst_async_outs", int'({timeset, alarmset, dayadv, dateadv, monthadv, minadv, hrsadv}), 0);
      @(negedge clk) rst = 1'b1;
      repeat (4) @(negedge clk);
      adv_btn = 1'b0;
      repeat (2) @(negedge clk);
      watch(B_ADV, 1, 5);
      chk("rst_adv_nostb", anymask(5), 0);
      chk("rst_after_field", int'(field), 0);

      quiet = 0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (i == 1500 || i == 3100) begin
            #2 rst = 1'b0;
            @(negedge clk) rst = 1'b1;
         end
         if (quiet > 0) begin
            {alarm_btn, adv_btn, mode_btn} = 3'b000;
            quiet--;
         end else if ($urandom_range(0, 149) == 0) begin
            quiet = 40;
         end else begin
            mode_btn  = ($urandom_range(0, 15) == 0);
            alarm_btn = ($urandom_range(0, 23) == 0);
            if ($urandom_range(0, 5) == 0) adv_btn = ~adv_btn;
         end
      end
      {alarm_btn, adv_btn, mode_btn} = 3'b000;
      repeat (3) @(negedge clk);
      run_cmp = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
